// File: rtl/alu16_reg.sv
// alu16_reg: registered 16-bit ALU execute stage.
// The result and carry-out are computed combinationally from A, B, opcode and Cin,
// then captured on every rising CLK edge (1-cycle latency, no enable).
// RST_N clears Y/Cout asynchronously.
module alu16_reg #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  input  logic             Cin,
  output logic [WIDTH-1:0] Y,
  output logic             Cout
);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SBC   = 4'h3;
  localparam logic [3:0] OP_INC   = 4'h4;
  localparam logic [3:0] OP_DEC   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_NOT   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_ASR   = 4'hC;
  localparam logic [3:0] OP_RCL   = 4'hD;
  localparam logic [3:0] OP_RCR   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] y_d, y_q;
  logic             cout_d, cout_q;

  // Select the second adder operand and carry-in; all arithmetic ops share one adder.
  always_comb begin
    add_b = B;
    add_c = 1'b0;
    case (opcode)
      OP_ADD: begin add_b = B;                add_c = 1'b0; end
      OP_ADC: begin add_b = B;                add_c = Cin;  end
      OP_SUB: begin add_b = ~B;               add_c = 1'b1; end
      OP_SBC: begin add_b = ~B;               add_c = Cin;  end
      OP_INC: begin add_b = '0;               add_c = 1'b1; end
      OP_DEC: begin add_b = {WIDTH{1'b1}};    add_c = 1'b0; end
      default: begin add_b = B;               add_c = 1'b0; end
    endcase
    sum = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
  end

  // Next-state result and carry for every opcode; the map is full so no X can escape.
  always_comb begin
    y_d    = '0;
    cout_d = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
        y_d    = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
      end
      OP_AND:   y_d = A & B;
      OP_OR:    y_d = A | B;
      OP_XOR:   y_d = A ^ B;
      OP_NOT:   y_d = ~A;
      OP_SHL: begin
        y_d    = {A[WIDTH-2:0], 1'b0};
        cout_d = A[WIDTH-1];
      end
      OP_SHR: begin
        y_d    = {1'b0, A[WIDTH-1:1]};
        cout_d = A[0];
      end
      OP_ASR: begin
        y_d    = {A[WIDTH-1], A[WIDTH-1:1]};
        cout_d = A[0];
      end
      OP_RCL: begin
        y_d    = {A[WIDTH-2:0], Cin};
        cout_d = A[WIDTH-1];
      end
      OP_RCR: begin
        y_d    = {Cin, A[WIDTH-1:1]};
        cout_d = A[0];
      end
      OP_PASSB: y_d = B;
      default: begin
        y_d    = '0;
        cout_d = 1'b0;
      end
    endcase
  end

  // Output registers: capture every edge, cleared asynchronously by RST_N.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      cout_q <= cout_d;
    end
  end

  assign Y    = y_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_alu16_reg.sv
// Testbench for alu16_reg: directed vector table, latency sweep with mid-stream
// reset, and random stimulus against an arithmetic reference model.
module tb_alu16_reg;

  logic        CLK;
  logic        RST_N;
  logic [15:0] A, B;
  logic [3:0]  opcode;
  logic        Cin;
  logic [15:0] Y;
  logic        Cout;

  logic clk_run;
  int   n_checks;
  int   n_fail;

  alu16_reg #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B),
    .opcode(opcode), .Cin(Cin), .Y(Y), .Cout(Cout)
  );

  initial CLK = 1'b0;
  always begin
    #5;
    if (clk_run) CLK = ~CLK;
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] ey;
    logic        ec;
  } vec_t;

  vec_t vecs[22];

  // Reference model: plain modular arithmetic on unsigned integers.
  function automatic void model(input int unsigned op, input int unsigned a,
                                input int unsigned b, input int unsigned ci,
                                output int unsigned y, output int unsigned c);
    int unsigned m, s;
    m = 65536;
    s = 0;
    y = 0;
    c = 0;
    case (op)
      0:  s = a + b;
      1:  s = a + b + ci;
      2:  s = a + (m - 1 - b) + 1;
      3:  s = a + (m - 1 - b) + ci;
      4:  s = a + 1;
      5:  s = a + m - 1;
      default: s = 0;
    endcase
    case (op)
      0, 1, 2, 3, 4, 5: begin y = s % m; c = s / m; end
      6:  y = a & b;
      7:  y = a | b;
      8:  y = a ^ b;
      9:  y = (m - 1) - a;
      10: begin y = (a * 2) % m;                         c = a / (m / 2); end
      11: begin y = a / 2;                               c = a % 2; end
      12: begin y = a / 2 + ((a >= m / 2) ? m / 2 : 0);  c = a % 2; end
      13: begin y = (a * 2) % m + ci;                    c = a / (m / 2); end
      14: begin y = a / 2 + ci * (m / 2);                c = a % 2; end
      default: y = b;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] ey, input logic ec);
    n_checks++;
    if (Y !== ey || Cout !== ec) begin
      n_fail++;
      $display("FAIL %s: got Y=%h Cout=%b, expected Y=%h Cout=%b", name, Y, Cout, ey, ec);
    end
  endtask

  initial begin
    int unsigned my, mc;
    logic [15:0] prev_y;
    logic        prev_c;
    bit          have_prev;

    n_checks = 0;
    n_fail   = 0;
    clk_run  = 1'b0;

    vecs[0]  = '{4'h1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1}; // ADC wrap
    vecs[1]  = '{4'h4, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1'b1}; // INC wrap
    vecs[2]  = '{4'h2, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0}; // SUB borrow
    vecs[3]  = '{4'h2, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1}; // SUB no borrow
    vecs[4]  = '{4'h5, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0}; // DEC of 0
    vecs[5]  = '{4'h6, 16'h0F0F, 16'h00FF, 1'b1, 16'h000F, 1'b0}; // AND
    vecs[6]  = '{4'h7, 16'h0F0F, 16'h00FF, 1'b1, 16'h0FFF, 1'b0}; // OR
    vecs[7]  = '{4'h8, 16'h0F0F, 16'h00FF, 1'b1, 16'h0FF0, 1'b0}; // XOR
    vecs[8]  = '{4'h9, 16'h0F0F, 16'h00FF, 1'b1, 16'hF0F0, 1'b0}; // NOT
    vecs[9]  = '{4'hF, 16'h0F0F, 16'h00FF, 1'b1, 16'h00FF, 1'b0}; // PASSB
    vecs[10] = '{4'hA, 16'h8015, 16'h0000, 1'b1, 16'h002A, 1'b1}; // SHL
    vecs[11] = '{4'hB, 16'h8015, 16'h0000, 1'b1, 16'h400A, 1'b1}; // SHR
    vecs[12] = '{4'hC, 16'h8015, 16'h0000, 1'b1, 16'hC00A, 1'b1}; // ASR
    vecs[13] = '{4'hD, 16'h8015, 16'h0000, 1'b1, 16'h002B, 1'b1}; // RCL
    vecs[14] = '{4'hE, 16'h8015, 16'h0000, 1'b1, 16'hC00A, 1'b1}; // RCR
    vecs[15] = '{4'h3, 16'h0007, 16'h0005, 1'b0, 16'h0001, 1'b1}; // SBC cin=0
    vecs[16] = '{4'h0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1}; // ADD carry
    vecs[17] = '{4'h5, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1}; // DEC of 1
    vecs[18] = '{4'h0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0}; // ADD ignores Cin
    vecs[19] = '{4'hE, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1}; // RCR cin=0
    vecs[20] = '{4'hC, 16'h4000, 16'h0000, 1'b1, 16'h2000, 1'b0}; // ASR positive
    vecs[21] = '{4'h4, 16'h1234, 16'hFFFF, 1'b1, 16'h1235, 1'b0}; // INC ignores Cin

    // Reset with the clock stopped must clear outputs immediately.
    A = 16'hFFFF; B = 16'hFFFF; opcode = 4'h0; Cin = 1'b1;
    RST_N = 1'b1;
    #2;
    RST_N = 1'b0;
    #3;
    check("reset_async", 16'h0000, 1'b0);
    #10;
    check("reset_hold", 16'h0000, 1'b0);

    // Release, then first edge captures.
    RST_N = 1'b0;
    A = 16'h1234; B = 16'h0001; opcode = 4'h0; Cin = 1'b0;
    #2;
    RST_N = 1'b1;
    #2;
    check("post_release_no_edge", 16'h0000, 1'b0);
    clk_run = 1'b1;
    @(posedge CLK); #1;
    check("first_capture", 16'h1235, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      A = vecs[i].a; B = vecs[i].b; opcode = vecs[i].op; Cin = vecs[i].cin;
      @(posedge CLK); #1;
      check($sformatf("vec%0d_op%h", i, vecs[i].op), vecs[i].ey, vecs[i].ec);
    end

    // Latency sweep: each output reflects the previous edge's inputs; reset mid-sweep.
    have_prev = 1'b0;
    prev_y = '0;
    prev_c = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (have_prev) check($sformatf("sweep%0d", i), prev_y, prev_c);
      A = 16'(i + 1); B = 16'(i + 1); opcode = 4'(i % 16); Cin = 1'(i % 2);
      model(opcode, A, B, Cin, my, mc);
      prev_y = my[15:0];
      prev_c = mc[0];
      have_prev = 1'b1;
      if (i == 20) begin
        #2;
        RST_N = 1'b0;
        #1;
        check("sweep_reset_async", 16'h0000, 1'b0);
        @(posedge CLK); #1;
        check("sweep_reset_hold", 16'h0000, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        have_prev = 1'b0;
      end
    end

    // Random stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      A = 16'($urandom); B = 16'($urandom);
      opcode = 4'($urandom_range(0, 15)); Cin = 1'($urandom_range(0, 1));
      model(opcode, A, B, Cin, my, mc);
      @(posedge CLK); #1;
      check($sformatf("rand%0d_op%h", i, opcode), my[15:0], mc[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
